uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchroniser, start-bit glitch filter, configurable framing, receive FIFO with sticky overrun.
// Optional macro UART_RX_MAJORITY_EN selects 2-of-3 majority bit sampling; otherwise bits are a single sample.
module uart_rx_fifo #(
  parameter int BAUD        = 9_600,
  parameter int INPUT_CLOCK = 16_000_000,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 new_data,
  input  logic                 ack_data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int CPB   = INPUT_CLOCK / BAUD;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB + 1);
  localparam int BW    = 4;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = DATA_BITS + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  logic r_rx_s1, r_rx_s2;
  logic w_rx, w_smp;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= i_rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  assign w_rx = r_rx_s2;

`ifdef UART_RX_MAJORITY_EN
  logic r_rx_d1, r_rx_d2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_d1 <= 1'b1;
      r_rx_d2 <= 1'b1;
    end else begin
      r_rx_d1 <= w_rx;
      r_rx_d2 <= r_rx_d1;
    end
  end

  // The decision clock holds the +1 sample; the window is centred one clock earlier.
  assign w_smp = (w_rx & r_rx_d1) | (w_rx & r_rx_d2) | (r_rx_d1 & r_rx_d2);
`else
  assign w_smp = w_rx;
`endif

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [BW-1:0]        r_bcnt, w_bcnt_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_ferr, w_ferr_nxt;
  logic                 r_perr, w_perr_nxt;
  logic                 w_tick;
  logic                 w_push;
  logic                 w_push_ferr;

  assign w_tick = (r_cnt == CNT_W'(CPB - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_shift <= w_shift_nxt;
      r_ferr  <= w_ferr_nxt;
      r_perr  <= w_perr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bcnt_nxt  = r_bcnt;
    w_shift_nxt = r_shift;
    w_ferr_nxt  = r_ferr;
    w_perr_nxt  = r_perr;
    w_push      = 1'b0;
    w_push_ferr = r_ferr;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_rx) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_W'(HALF - 1)) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
          w_bcnt_nxt  = '0;
          w_ferr_nxt  = 1'b0;
          w_perr_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_smp, r_shift[DATA_BITS-1:1]};
          if (r_bcnt == BW'(DATA_BITS - 1)) begin
            w_bcnt_nxt  = '0;
            w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bcnt_nxt = r_bcnt + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          // Odd parity expects the XOR over data and parity to be 1, even expects 0.
          w_perr_nxt  = (^r_shift) ^ w_smp ^ (PARITY == 1);
          w_state_nxt = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_cnt_nxt = '0;
          if (!w_smp) w_ferr_nxt = 1'b1;
          if (r_bcnt == BW'(STOP_BITS - 1)) begin
            w_bcnt_nxt  = '0;
            w_push      = 1'b1;
            w_push_ferr = r_ferr | ~w_smp;
            w_state_nxt = w_smp ? S_IDLE : S_BREAK;
          end else begin
            w_bcnt_nxt = r_bcnt + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_BREAK: begin
        w_cnt_nxt = '0;
        if (w_rx) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr, r_rd;
  logic [AW:0]   w_wr_nxt, w_rd_nxt;
  logic          w_full, w_pop, w_wr_en, w_ovr_set, w_empty_nxt;
  logic [EW-1:0] w_push_ent, w_head_nxt;

  assign w_full      = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop       = ack_data & new_data;
  assign w_wr_en     = w_push & (~w_full | w_pop);
  assign w_ovr_set   = w_push & w_full & ~w_pop;
  assign w_push_ent  = {r_perr, w_push_ferr, r_shift};
  assign w_wr_nxt    = r_wr + {{AW{1'b0}}, w_wr_en};
  assign w_rd_nxt    = r_rd + {{AW{1'b0}}, w_pop};
  assign w_empty_nxt = (w_wr_nxt == w_rd_nxt);
  // A word written this cycle into the slot that becomes the head is forwarded straight to the outputs.
  assign w_head_nxt  = (w_wr_en && (w_rd_nxt[AW-1:0] == r_wr[AW-1:0])) ? w_push_ent
                                                                       : r_mem[w_rd_nxt[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr[AW-1:0]] <= w_push_ent;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr       <= '0;
      r_rd       <= '0;
      data       <= '0;
      new_data   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      r_wr     <= w_wr_nxt;
      r_rd     <= w_rd_nxt;
      new_data <= ~w_empty_nxt;
      if (!w_empty_nxt) begin
        data       <= w_head_nxt[DATA_BITS-1:0];
        frame_err  <= w_head_nxt[DATA_BITS];
        parity_err <= w_head_nxt[DATA_BITS+1];
      end else begin
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
      end
      if (w_ovr_set)  overrun <= 1'b1;
      else if (w_pop) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench: 8N1 and 8E1 receivers at 16 clocks per bit, directed cases plus randomized rounds against a queue model.
module tb_uart_rx_fifo;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic       ack_a = 1'b0, ack_b = 1'b0;
  logic [7:0] data_a, data_b;
  logic       nd_a, nd_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.BAUD(1_000_000), .INPUT_CLOCK(16_000_000), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_a), .data(data_a), .new_data(nd_a),
    .ack_data(ack_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a));

  uart_rx_fifo #(.BAUD(1_000_000), .INPUT_CLOCK(16_000_000), .DATA_BITS(8),
                 .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_b), .data(data_b), .new_data(nd_b),
    .ack_data(ack_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
  endtask

  // One frame: start, 8 data bits LSB first, optional parity bit, one stop bit; line is left at the stop value.
  task automatic send(input int sel, input logic [7:0] d, input bit has_par, input logic pbit, input logic stopv);
    set_rx(sel, 1'b0);
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, d[i]);
      tick(CPB);
    end
    if (has_par) begin
      set_rx(sel, pbit);
      tick(CPB);
    end
    set_rx(sel, stopv);
    tick(CPB);
  endtask

  task automatic idle(input int sel, input int nbits);
    set_rx(sel, 1'b1);
    tick(CPB * nbits);
  endtask

  task automatic wait_nd(input int sel, input string tag);
    int k = 0;
    while (((sel == 0) ? nd_a : nd_b) !== 1'b1 && k < 200) begin
      tick(1);
      k++;
    end
    check(tag, (sel == 0) ? nd_a : nd_b, 1);
  endtask

  task automatic pop(input int sel);
    if (sel == 0) ack_a = 1'b1;
    else          ack_b = 1'b1;
    tick(1);
    ack_a = 1'b0;
    ack_b = 1'b0;
  endtask

  logic [8:0]  q[$];
  logic [8:0]  ent;
  bit          ovr_m;
  logic [7:0]  d;
  logic        s, bad;
  int          k;

  initial begin
    tick(3);
    check("rst_nd", nd_a, 0);
    check("rst_data", data_a, 0);
    check("rst_fe", fe_a, 0);
    check("rst_pe", pe_b, 0);
    check("rst_ov", ov_a, 0);
    rst_n = 1'b1;
    tick(4);

    send(0, 8'hA5, 0, 1'b0, 1'b1);
    idle(0, 1);
    wait_nd(0, "a5_nd");
    check("a5_data", data_a, 8'hA5);
    check("a5_fe", fe_a, 0);
    check("a5_pe", pe_a, 0);
    pop(0);
    check("a5_empty", nd_a, 0);

    rx_a = 1'b0;
    tick(5);
    rx_a = 1'b1;
    tick(48);
    check("glitch_nd", nd_a, 0);
    send(0, 8'h5A, 0, 1'b0, 1'b1);
    idle(0, 1);
    wait_nd(0, "post_glitch_nd");
    check("post_glitch_data", data_a, 8'h5A);
    pop(0);

    send(1, 8'h07, 1, 1'b0, 1'b1);
    idle(1, 1);
    wait_nd(1, "par0_nd");
    check("par0_data", data_b, 8'h07);
    check("par0_pe", pe_b, 1);
    pop(1);
    send(1, 8'h07, 1, 1'b1, 1'b1);
    idle(1, 1);
    wait_nd(1, "par1_nd");
    check("par1_pe", pe_b, 0);
    check("par1_fe", fe_b, 0);
    pop(1);
    for (int i = 0; i < 6; i++) begin
      d   = 8'($urandom);
      bad = 1'($urandom);
      send(1, d, 1, (^d) ^ bad, 1'b1);
      idle(1, 1);
      wait_nd(1, "rpar_nd");
      check("rpar_data", data_b, d);
      check("rpar_pe", pe_b, bad);
      pop(1);
    end
    check("rpar_empty", nd_b, 0);

    send(0, 8'h33, 0, 1'b0, 1'b0);
    tick(40);
    check("brk_nd", nd_a, 1);
    check("brk_data", data_a, 8'h33);
    check("brk_fe", fe_a, 1);
    pop(0);
    tick(64);
    check("brk_no_frame", nd_a, 0);
    idle(0, 2);
    send(0, 8'h66, 0, 1'b0, 1'b1);
    idle(0, 1);
    wait_nd(0, "brk_after_nd");
    check("brk_after_data", data_a, 8'h66);
    check("brk_after_fe", fe_a, 0);
    pop(0);

    for (int i = 1; i <= 5; i++) begin
      send(0, 8'(i), 0, 1'b0, 1'b1);
      idle(0, 1);
    end
    check("ovr_set", ov_a, 1);
    for (int i = 1; i <= 4; i++) begin
      check("ovr_nd", nd_a, 1);
      check("ovr_data", data_a, i);
      pop(0);
      if (i == 1) check("ovr_clr", ov_a, 0);
    end
    check("ovr_empty", nd_a, 0);

    for (int r = 0; r < 4; r++) begin
      ovr_m = 1'b0;
      k = $urandom_range(1, 6);
      for (int i = 0; i < k; i++) begin
        d = 8'($urandom);
        s = ($urandom_range(0, 3) != 0);
        send(0, d, 0, 1'b0, s);
        idle(0, 2);
        if (q.size() < 4) q.push_back({~s, d});
        else              ovr_m = 1'b1;
      end
      check("rnd_ov", ov_a, ovr_m);
      while (q.size() > 0) begin
        ent = q.pop_front();
        check("rnd_nd", nd_a, 1);
        check("rnd_data", data_a, ent[7:0]);
        check("rnd_fe", fe_a, ent[8]);
        pop(0);
        ovr_m = 1'b0;
        check("rnd_ov_pop", ov_a, ovr_m);
      end
      check("rnd_empty", nd_a, 0);
    end

    send(0, 8'h11, 0, 1'b0, 1'b1);
    idle(0, 1);
    check("pre_rst_nd", nd_a, 1);
    rx_a = 1'b0;
    tick(CPB);
    rx_a = 1'b1;
    tick(CPB);
    rx_a = 1'b0;
    tick(8);
    rst_n = 1'b0;
    tick(2);
    check("mid_rst_nd", nd_a, 0);
    check("mid_rst_data", data_a, 0);
    check("mid_rst_fe", fe_a, 0);
    check("mid_rst_pe", pe_a, 0);
    check("mid_rst_ov", ov_a, 0);
    rx_a = 1'b1;
    rst_n = 1'b1;
    idle(0, 2);
    check("post_rst_idle", nd_a, 0);
    send(0, 8'h3C, 0, 1'b0, 1'b1);
    idle(0, 1);
    wait_nd(0, "3c_nd");
    check("3c_data", data_a, 8'h3C);
    check("3c_fe", fe_a, 0);
    check("3c_pe", pe_a, 0);
    check("3c_ov", ov_a, 0);
    pop(0);
    check("3c_empty", nd_a, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
